// File: rtl/detect_event_logger_if.sv
// Drain port of the detection event logger: show-ahead valid/ready stream
// carrying one timestamp per entry.
interface detect_event_logger_if #(
    parameter int TS_W = 16
);
    logic            out_valid;
    logic            out_ready;
    logic [TS_W-1:0] out_ts;

    modport master (output out_valid, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/detect_event_logger.sv
// Timestamps each detection strobe with a free-running counter and queues it
// in a small FIFO drained through a valid/ready port. Saturating event/drop
// counters and a sticky overflow flag give status visibility.
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     detected,
    input  logic                     clear,
    detect_event_logger_if.master    bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         event_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop     = !empty && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = detected && (!full || pop);
    assign drop    = detected && full && !pop;

    assign bus.out_valid = !empty;
    // Show-ahead head; forced to zero when nothing is queued.
    assign bus.out_ts    = empty ? '0 : mem[head];

    // Storage needs no reset: it is only observed through a non-empty level.
    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[tail] <= ts;
    end

    // Timestamp, pointers and occupancy; clear overrides any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else if (clear) begin
            ts    <= '0;
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (push_ok)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !push_ok)
                level <= level - 1'b1;
        end
    end

    // Status counters: every attempt counts, drops counted separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            event_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (detected && event_count != '1)
                event_count <= event_count + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule
